// File: rtl/la_dsync_pkg.sv
// Shared constants and helpers for the la_dsync_filter synchroniser/filter block.
package la_dsync_pkg;

    localparam int LA_DSYNC_MIN_STAGES = 2;

    // Filter counter width; never below 1 so a degenerate filter still elaborates.
    function automatic int cnt_width(input int filter);
        int w;
        w = $clog2(filter + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffrnq_1.sv
// Behavioural stand-in for the gf180mcu DFF with active-low async reset; the cell library replaces it in implementation.
module gf180mcu_fd_sc_mcu9t5v0__dffrnq_1 (
    input  logic D,
    input  logic RN,
    input  logic CLK,
    output logic Q
);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) Q <= 1'b0;
        else     Q <= D;
    end

endmodule

// File: rtl/la_dsync_filter_ch.sv
// One channel of la_dsync_filter: stability counter, filtered level, edge pulses and busy flag.
module la_dsync_filter_ch
    import la_dsync_pkg::*;
#(
    parameter int   FILTER = 4,
    parameter logic RSTVAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_s,
    output logic o_out,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    logic w_out;
    logic r_out_q;

    generate
        if (FILTER == 0) begin : g_bypass
            assign w_out  = i_s;
            assign o_busy = 1'b0;
        end else begin : g_filt
            localparam int CW = cnt_width(FILTER);
            logic [CW-1:0] r_cnt;
            logic          r_out;

            // Any return of s to the current level aborts a pending transition.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_out <= RSTVAL;
                end else if (i_s == r_out) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(FILTER - 1)) begin
                    r_out <= i_s;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign w_out  = r_out;
            assign o_busy = |r_cnt;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_out_q <= RSTVAL;
        else       r_out_q <= w_out;
    end

    assign o_out  = w_out;
    assign o_rise = w_out & ~r_out_q;
    assign o_fall = ~w_out & r_out_q;

endmodule

// File: rtl/la_dsync_filter.sv
// Multi-channel synchroniser + glitch filter + edge detect.
// Optional LA_DSYNC_FILTER_SIM_RND_EN (simulation only) adds 0/+1 cycle metastability jitter.
module la_dsync_filter
    import la_dsync_pkg::*;
#(
    parameter string            PROP   = "DEFAULT",
    parameter int               WIDTH  = 1,
    parameter int               STAGES = 2,
    parameter int               FILTER = 4,
    parameter logic [WIDTH-1:0] RSTVAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    generate
        if (STAGES < LA_DSYNC_MIN_STAGES) begin : g_bad_stages
            $error("la_dsync_filter: STAGES must be >= 2");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("la_dsync_filter: WIDTH must be >= 1");
        end
        if (PROP == "") begin : g_bad_prop
            $error("la_dsync_filter: PROP must name a property set");
        end
    endgenerate

    logic                          w_rst_n;
    wire  [WIDTH-1:0][STAGES-1:0]  w_chain;
    logic [WIDTH-1:0]              w_last;
    logic [WIDTH-1:0]              w_s;

    assign w_rst_n = ~reset;

    // The reset-to-0 cells hold data XORed with RSTVAL, so reset yields RSTVAL.
    genvar gi, gk;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            for (gk = 0; gk < STAGES; gk++) begin : g_stage
                if (gk == 0) begin : g_first
                    gf180mcu_fd_sc_mcu9t5v0__dffrnq_1 u_sync (
                        .D   (in[gi] ^ RSTVAL[gi]),
                        .RN  (w_rst_n),
                        .CLK (clk),
                        .Q   (w_chain[gi][gk])
                    );
                end else begin : g_next
                    gf180mcu_fd_sc_mcu9t5v0__dffrnq_1 u_sync (
                        .D   (w_chain[gi][gk-1]),
                        .RN  (w_rst_n),
                        .CLK (clk),
                        .Q   (w_chain[gi][gk])
                    );
                end
            end
            assign w_last[gi] = w_chain[gi][STAGES-1];
        end
    endgenerate

`ifdef LA_DSYNC_FILTER_SIM_RND_EN
    logic [WIDTH-1:0] r_extra;
    logic [WIDTH-1:0] r_pick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_extra <= '0;
            r_pick  <= '0;
        end else begin
            r_extra <= w_last;
            for (int i = 0; i < WIDTH; i++) r_pick[i] <= 1'({$random} % 2);
        end
    end

    assign w_s = ((r_pick & r_extra) | (~r_pick & w_last)) ^ RSTVAL;
`else
    assign w_s = w_last ^ RSTVAL;
`endif

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            la_dsync_filter_ch #(
                .FILTER (FILTER),
                .RSTVAL (RSTVAL[gi])
            ) u_ch (
                .clk    (clk),
                .reset  (reset),
                .i_s    (w_s[gi]),
                .o_out  (out[gi]),
                .o_rise (rise[gi]),
                .o_fall (fall[gi]),
                .o_busy (busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_la_dsync_filter.sv
// Directed bench for la_dsync_filter: three configurations share one clock and reset.
module tb_la_dsync_filter;

    logic       clk;
    logic       rst;
    logic [3:0] in_a, out_a, rise_a, fall_a, busy_a;
    logic [3:0] in_b, out_b, rise_b, fall_b, busy_b;
    logic [3:0] in_c, out_c, rise_c, fall_c, busy_c;
    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: filtered, non-zero reset value
    la_dsync_filter #(.PROP("DEFAULT"), .WIDTH(4), .STAGES(2), .FILTER(4), .RSTVAL(4'b1010)) dut_a (
        .clk(clk), .reset(rst), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .busy(busy_a));
    // B: bypass, deeper chain
    la_dsync_filter #(.PROP("DEFAULT"), .WIDTH(4), .STAGES(3), .FILTER(0), .RSTVAL(4'b0000)) dut_b (
        .clk(clk), .reset(rst), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .busy(busy_b));
    // C: short filter for multi-channel behaviour
    la_dsync_filter #(.PROP("DEFAULT"), .WIDTH(4), .STAGES(2), .FILTER(2), .RSTVAL(4'b0000)) dut_c (
        .clk(clk), .reset(rst), .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c), .busy(busy_c));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        in_a = 4'b1010; in_b = 4'b0000; in_c = 4'b0000; rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_a !== 4'b1010 || rise_a !== 4'b0 || fall_a !== 4'b0 || busy_a !== 4'b0) begin
            failures++;
            $display("FAIL reset_async_a: out=%b rise=%b fall=%b busy=%b want out=1010 others 0", out_a, rise_a, fall_a, busy_a);
        end
        checks++;
        if (out_b !== 4'b0 || out_c !== 4'b0 || busy_b !== 4'b0 || busy_c !== 4'b0) begin
            failures++;
            $display("FAIL reset_async_bc: out_b=%b out_c=%b busy_b=%b busy_c=%b want all 0", out_b, out_c, busy_b, busy_c);
        end
        tick; tick;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            checks++;
            if (out_a !== 4'b1010 || rise_a !== 4'b0 || fall_a !== 4'b0 || busy_a !== 4'b0) begin
                failures++;
                $display("FAIL reset_release edge %0d: out=%b rise=%b fall=%b busy=%b want 1010/0/0/0", k, out_a, rise_a, fall_a, busy_a);
            end
        end
    endtask

    task automatic run_rise_ch0(input string name);
        logic [3:0] e_out, e_rise, e_busy;
        for (int k = 1; k <= 7; k++) begin
            tick;
            e_out  = (k >= 6) ? 4'b1011 : 4'b1010;
            e_rise = (k == 6) ? 4'b0001 : 4'b0000;
            e_busy = (k >= 3 && k <= 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (out_a !== e_out || rise_a !== e_rise || fall_a !== 4'b0 || busy_a !== e_busy) begin
                failures++;
                $display("FAIL %s edge %0d: out=%b rise=%b fall=%b busy=%b want %b/%b/0000/%b",
                         name, k, out_a, rise_a, fall_a, busy_a, e_out, e_rise, e_busy);
            end
        end
    endtask

    task automatic test_latency;
        in_a = 4'b1011;
        run_rise_ch0("latency");
    endtask

    task automatic test_glitch;
        logic [3:0] e_busy;
        in_a = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k == 3) in_a = 4'b1011;
            e_busy = (k >= 3 && k <= 5) ? 4'b0100 : 4'b0000;
            checks++;
            if (out_a !== 4'b1011 || rise_a !== 4'b0 || fall_a !== 4'b0 || busy_a !== e_busy) begin
                failures++;
                $display("FAIL glitch edge %0d: out=%b rise=%b fall=%b busy=%b want 1011/0000/0000/%b",
                         k, out_a, rise_a, fall_a, busy_a, e_busy);
            end
        end
    endtask

    task automatic test_bypass;
        logic       hist [0:24];
        logic       v, e_now, e_prev;
        logic [3:0] e_out, e_rise, e_fall;
        for (int i = 0; i <= 24; i++) hist[i] = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            v = (((k - 1) / 5) % 2) == 0;
            hist[k] = v;
            in_b = {1'b0, v, 2'b00};
            tick;
            e_now  = (k >= 3) ? hist[k-2] : 1'b0;
            e_prev = (k >= 4) ? hist[k-3] : 1'b0;
            e_out  = {1'b0, e_now, 2'b00};
            e_rise = {1'b0, e_now & ~e_prev, 2'b00};
            e_fall = {1'b0, ~e_now & e_prev, 2'b00};
            checks++;
            if (out_b !== e_out || rise_b !== e_rise || fall_b !== e_fall || busy_b !== 4'b0) begin
                failures++;
                $display("FAIL bypass edge %0d: out=%b rise=%b fall=%b busy=%b want %b/%b/%b/0000",
                         k, out_b, rise_b, fall_b, busy_b, e_out, e_rise, e_fall);
            end
        end
    endtask

    task automatic test_reset_mid_pend;
        rst = 1'b1;
        in_a = 4'b1010;
        tick; tick;
        rst = 1'b0;
        in_a = 4'b1011;
        tick; tick; tick; tick;
        checks++;
        if (busy_a !== 4'b0001 || out_a !== 4'b1010) begin
            failures++;
            $display("FAIL pend_before_reset: out=%b busy=%b want 1010/0001", out_a, busy_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_a !== 4'b1010 || busy_a !== 4'b0 || rise_a !== 4'b0) begin
            failures++;
            $display("FAIL pend_reset_async: out=%b busy=%b rise=%b want 1010/0000/0000", out_a, busy_a, rise_a);
        end
        tick; tick;
        rst = 1'b0;
        run_rise_ch0("pend_relatency");
    endtask

    task automatic run_multi(input string name, input logic [3:0] from_v, input logic [3:0] to_v);
        logic [3:0] e_out, e_rise, e_fall, e_busy;
        in_c = to_v;
        for (int k = 1; k <= 5; k++) begin
            tick;
            e_out  = (k >= 4) ? to_v : from_v;
            e_rise = (k == 4) ? (to_v & ~from_v) : 4'b0000;
            e_fall = (k == 4) ? (~to_v & from_v) : 4'b0000;
            e_busy = (k == 3) ? (to_v ^ from_v) : 4'b0000;
            checks++;
            if (out_c !== e_out || rise_c !== e_rise || fall_c !== e_fall || busy_c !== e_busy) begin
                failures++;
                $display("FAIL %s edge %0d: out=%b rise=%b fall=%b busy=%b want %b/%b/%b/%b",
                         name, k, out_c, rise_c, fall_c, busy_c, e_out, e_rise, e_fall, e_busy);
            end
        end
    endtask

    task automatic test_multi;
        run_multi("multi_rise", 4'b0000, 4'b1111);
        run_multi("multi_fall3", 4'b1111, 4'b0111);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_latency;
        test_glitch;
        test_bypass;
        test_reset_mid_pend;
        test_multi;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
